// File: rtl/mouse_send_byte.sv
`timescale 1ns/1ps
// mouse_send_byte: host-to-device PS/2 transmitter. Sends one command byte to the
// mouse by inhibiting the bus, issuing request-to-send, shifting 8 data bits LSB-first,
// then odd parity and stop, and finally checking the device ACK.
//
// Ports:
//   clk, rst_n           main clock, asynchronous active-low reset
//   i_ps2_clk/i_ps2_data raw (asynchronous) PS/2 line levels
//   o_clk_oe/o_data_oe   1 = pull the corresponding open-drain line low
//   i_valid/i_byte       send request and command byte, taken when o_ready=1
//   o_ready              high in IDLE only
//   o_busy               high in every state except IDLE (gates the byte receiver)
//   o_done/o_error       one-cycle completion pulses (ACK received / timeout or no ACK)
module mouse_send_byte #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_clk_oe,
    output logic       o_data_oe,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);

    localparam int unsigned MaxCycles =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StXfer,
        StWaitIdle,
        StDone,
        StErr
    } state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   sc_prev_q;
    logic                   sc;
    logic                   sd;
    logic                   fall;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      edge_q;
    logic [9:0]      shift_q;
    logic            clk_oe_q;
    logic            data_oe_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;

    // Idle bus level is high, so synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            sc_prev_q   <= 1'b1;
        end else begin
            clk_sync_q  <= SYNC_STAGES'({clk_sync_q, i_ps2_clk});
            data_sync_q <= SYNC_STAGES'({data_sync_q, i_ps2_data});
            sc_prev_q   <= sc;
        end
    end

    assign sc   = clk_sync_q[SYNC_STAGES-1];
    assign sd   = data_sync_q[SYNC_STAGES-1];
    assign fall = sc_prev_q & ~sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            edge_q    <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        // {stop, odd parity, data}; shifted out LSB-first.
                        shift_q  <= {1'b1, ~^i_byte, i_byte};
                        cnt_q    <= '0;
                        edge_q   <= '0;
                        clk_oe_q <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (cnt_q == InhibitLast) begin
                        data_oe_q <= 1'b1;  // start bit
                        state_q   <= StRts;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRts: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StXfer;
                end
                StXfer: begin
                    if (fall) begin
                        cnt_q  <= '0;
                        edge_q <= edge_q + 1'b1;
                        if (edge_q == 4'd10) begin
                            // Fall 11: device should be holding data low as ACK.
                            if (!sd) begin
                                state_q <= StWaitIdle;
                            end else begin
                                state_q   <= StErr;
                                error_q   <= 1'b1;
                                data_oe_q <= 1'b0;
                            end
                        end else begin
                            // Falls 1..10: data, parity, then stop (releases the line).
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b1, shift_q[9:1]};
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        state_q   <= StErr;
                        error_q   <= 1'b1;
                        data_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitIdle: begin
                    data_oe_q <= 1'b0;
                    if (sc && sd) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (cnt_q == TimeoutLast) begin
                        state_q <= StErr;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone, StErr: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign o_clk_oe  = clk_oe_q;
    assign o_data_oe = data_oe_q;
    assign o_ready   = ready_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;

endmodule

// File: tb/tb_mouse_send_byte.sv
`timescale 1ns/1ps
// Directed bench for mouse_send_byte with a PS/2 device model on wired-AND lines.
// Expected line bits are queued when a request is driven and popped as the device
// model samples the data line on each rising clock edge.
module tb_mouse_send_byte;

    localparam int unsigned Inh  = 20;
    localparam int unsigned To   = 200;
    localparam int unsigned Half = 20;
    // Raw line change -> 2 sync flops -> fall registered by the FSM.
    localparam int unsigned FallLat = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       ps2_clk;
    logic       ps2_data;
    logic       o_clk_oe;
    logic       o_data_oe;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    assign ps2_clk  = ~(o_clk_oe | dev_clk_low);
    assign ps2_data = ~(o_data_oe | dev_data_low);

    mouse_send_byte #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(To),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ps2_clk (ps2_clk),
        .i_ps2_data(ps2_data),
        .o_clk_oe  (o_clk_oe),
        .o_data_oe (o_data_oe),
        .i_valid   (i_valid),
        .i_byte    (i_byte),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    int   done_cnt = 0;
    int   err_cnt = 0;
    bit   both_seen = 1'b0;
    bit   long_pulse = 1'b0;
    bit   x_seen = 1'b0;
    bit   mon_en = 1'b0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if ($isunknown({o_clk_oe, o_data_oe})) x_seen <= 1'b1;
            if (o_done === 1'b1) done_cnt <= done_cnt + 1;
            if (o_error === 1'b1) err_cnt <= err_cnt + 1;
            if (o_done && o_error) both_seen <= 1'b1;
            if ((o_done | o_error) && prev_pulse) long_pulse <= 1'b1;
            prev_pulse <= o_done | o_error;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] b, input bit push);
        @(negedge clk);
        i_valid = 1'b1;
        i_byte  = b;
        if (push) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
            exp_q.push_back(~^b);
            exp_q.push_back(1'b1);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Returns the number of edges after the accept edge until data is pulled low (RTS).
    task automatic wait_xfer(input string tag, output int n);
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (o_data_oe) break;
        end
        @(posedge clk);
        #1;
        check({tag, "_xfer_clk_oe"}, o_clk_oe, 0);
        check({tag, "_xfer_data_oe"}, o_data_oe, 1);
    endtask

    // Clocks falls 1..n_falls; returns just after the last fall with the clock held low.
    task automatic dev_run(input string tag, input int n_falls, input bit ack);
        bit   unstable = 1'b0;
        logic ref_oe = 1'b0;
        logic exp_bit;
        for (int k = 1; k <= n_falls; k++) begin
            if (k > 1) begin
                repeat (Half) @(posedge clk);
                #1;
                dev_clk_low = 1'b0;
                exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("%s_bit%0d", tag, k - 1), ps2_data, exp_bit);
                if (k == 11) dev_data_low = ack;
            end
            for (int c = 0; c < int'(Half); c++) begin
                @(posedge clk);
                #1;
                if (c == 0) ref_oe = o_data_oe;
                else if (o_data_oe !== ref_oe) unstable = 1'b1;
            end
            dev_clk_low = 1'b1;
        end
        check({tag, "_data_stable_clk_high"}, unstable, 0);
    endtask

    task automatic dev_finish();
        repeat (Half) @(posedge clk);
        #1;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        for (n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (o_done) break;
        end
        check({tag, "_done_seen"}, n <= 300, 1);
        check({tag, "_no_error"}, o_error, 0);
        @(posedge clk);
        #1;
        check({tag, "_ready_back"}, o_ready, 1);
    endtask

    initial begin
        int n;
        int d0;
        int e0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_clk_oe", o_clk_oe, 0);
        check("rst_data_oe", o_data_oe, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        // 1: 0xF4 with ACK, plus accept/RTS latency
        send_req(8'hF4, 1'b1);
        check("c1_accept_clk_oe", o_clk_oe, 1);
        check("c1_accept_data_oe", o_data_oe, 0);
        check("c1_accept_ready", o_ready, 0);
        check("c1_accept_busy", o_busy, 1);
        wait_xfer("c1", n);
        check("c1_rts_latency", n, Inh);
        dev_run("c1", 11, 1'b1);
        dev_finish();
        wait_done("c1");
        check("c1_sb_empty", exp_q.size(), 0);

        // 2: 0x00 then 0xFF back-to-back (parity 1 both)
        send_req(8'h00, 1'b1);
        wait_xfer("c2a", n);
        dev_run("c2a", 11, 1'b1);
        dev_finish();
        wait_done("c2a");
        send_req(8'hFF, 1'b1);
        wait_xfer("c2b", n);
        dev_run("c2b", 11, 1'b1);
        dev_finish();
        wait_done("c2b");
        check("c2_sb_empty", exp_q.size(), 0);

        // 3: missing ACK at fall 11
        send_req(8'hA5, 1'b1);
        wait_xfer("c3", n);
        dev_run("c3", 11, 1'b0);
        for (n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (o_error) break;
        end
        check("c3_nack_err_latency", n, FallLat);
        check("c3_clk_oe_rel", o_clk_oe, 0);
        check("c3_data_oe_rel", o_data_oe, 0);
        check("c3_no_done", o_done, 0);
        @(posedge clk);
        #1;
        check("c3_err_one_cycle", o_error, 0);
        check("c3_ready", o_ready, 1);
        dev_finish();
        repeat (10) @(posedge clk);

        // 4: device stops clocking after fall 4 -> timeout
        send_req(8'hF4, 1'b1);
        wait_xfer("c4", n);
        dev_run("c4", 4, 1'b1);
        for (n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (o_error) break;
        end
        check("c4_timeout_latency", n, FallLat + To);
        check("c4_clk_oe_rel", o_clk_oe, 0);
        check("c4_data_oe_rel", o_data_oe, 0);
        dev_clk_low = 1'b0;
        exp_q.delete();
        repeat (10) @(posedge clk);

        // 5: request during XFER is ignored
        send_req(8'hF4, 1'b1);
        wait_xfer("c5", n);
        send_req(8'h12, 1'b0);
        dev_run("c5", 11, 1'b1);
        dev_finish();
        wait_done("c5");
        repeat (30) @(posedge clk);
        #1;
        check("c5_still_idle_ready", o_ready, 1);
        check("c5_still_idle_busy", o_busy, 0);
        check("c5_still_idle_clk_oe", o_clk_oe, 0);

        // 6: asynchronous reset at fall 6
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'h0F, 1'b1);
        wait_xfer("c6", n);
        dev_run("c6", 6, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("c6_pre_rst_data_oe", o_data_oe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("c6_rst_clk_oe", o_clk_oe, 0);
        check("c6_rst_data_oe", o_data_oe, 0);
        check("c6_rst_ready", o_ready, 1);
        check("c6_rst_busy", o_busy, 0);
        dev_clk_low = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("c6_ready_after", o_ready, 1);
        check("c6_no_done", done_cnt, d0);
        check("c6_no_error", err_cnt, e0);
        exp_q.delete();

        // Whole-run monitors
        check("total_done", done_cnt, 4);
        check("total_error", err_cnt, 2);
        check("done_error_together", both_seen, 0);
        check("pulse_width", long_pulse, 0);
        check("oe_unknown", x_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
